// File: rtl/mux_stream_pkg.sv
// Shared constants for the mux_stream registered stream multiplexer.
// Optional per-channel beat counters are enabled with MUX_STREAM_STATS_EN.
package mux_stream_pkg;

  localparam int DATA_W_DEFAULT = 136;
  localparam int N_CH_DEFAULT   = 3;
  localparam int CNT_W          = 32;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/mux_rr_arb.sv
// Combinational round-robin arbiter: grants the first valid channel after ptr,
// wrapping from N_CH-1 back to 0.
module mux_rr_arb #(
  parameter int N_CH  = 3,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  in_valid,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  // Walk offsets from farthest to nearest so the nearest valid channel wins.
  always_comb begin
    int idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = (int'(ptr) + k) % N_CH;
      if (in_valid[SEL_W'(idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_stream.sv
// N-channel registered stream mux with fixed-select or round-robin arbitration.
// Define MUX_STREAM_STATS_EN to add the beat_cnt per-channel transfer counters.
module mux_stream
  import mux_stream_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEFAULT,
  parameter  int N_CH   = N_CH_DEFAULT,
  localparam int SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rr_mode,
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic [N_CH*DATA_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch
`ifdef MUX_STREAM_STATS_EN
  ,
  output logic [N_CH*CNT_W-1:0]  beat_cnt
`endif
);

  logic             accept;
  logic             sel_ok;
  logic             fix_valid;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             xfer;
  logic [SEL_W-1:0] ptr_q;

  mux_rr_arb #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_arb (
    .in_valid  (in_valid),
    .ptr       (ptr_q),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  assign accept = !out_valid || out_ready;

  // An out-of-range select grants nothing rather than aliasing a channel.
  always_comb begin
    sel_ok    = ({1'b0, sel} < (SEL_W+1)'(N_CH));
    fix_valid = 1'b0;
    if (sel_ok) begin
      fix_valid = in_valid[sel];
    end
    if (rr_mode == MODE_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fix_valid;
      gnt_idx   = sel;
    end
  end

  assign xfer = !rst && accept && gnt_valid;

  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr_q     <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*DATA_W +: DATA_W];
      out_ch    <= gnt_idx;
      if (rr_mode == MODE_RR) begin
        ptr_q <= gnt_idx;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef MUX_STREAM_STATS_EN
  logic [N_CH-1:0][CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (xfer) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
    end
  end

  assign beat_cnt = cnt_q;
`endif

endmodule
